// File: rtl/pio_read_arbiter.sv
// Round-robin arbiter and read sequencer sharing one registered-read PIO slave among NUM_REQ requesters.
// Optional build macro PIO_RDCHG_EN adds rsp_changed_o and a per-address shadow of the last returned word.
module pio_read_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_W     = 2,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    output logic [NUM_REQ-1:0]          rsp_valid_o,
    output logic [DATA_W-1:0]           rsp_data_o,
`ifdef PIO_RDCHG_EN
    output logic                        rsp_changed_o,
`endif
    output logic                        busy_o,
    output logic [ADDR_W-1:0]           slv_address_o,
    output logic                        slv_read_o,
    input  logic [DATA_W-1:0]           slv_readdata_i
);

    localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(RD_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 read_q, read_d;
    logic                 busy_q, busy_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;

    logic                 win_vld_c;
    logic [ID_W-1:0]      win_id_c;
    logic [ADDR_W-1:0]    win_addr_c;

    // (base + off) mod NUM_REQ, without relying on a power-of-two requester count
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
        logic [ID_W:0] sum;
        sum = {1'b0, base} + (ID_W+1)'(off);
        if (sum >= (ID_W+1)'(NUM_REQ)) begin
            sum = sum - (ID_W+1)'(NUM_REQ);
        end
        return ID_W'(sum);
    endfunction

    // Round-robin pick: scanning offsets high to low leaves the nearest requester to the pointer as winner
    always_comb begin
        win_vld_c  = 1'b0;
        win_id_c   = '0;
        win_addr_c = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid_i[wrap_add(ptr_q, k)]) begin
                win_vld_c = 1'b1;
                win_id_c  = wrap_add(ptr_q, k);
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win_id_c == ID_W'(k)) begin
                win_addr_c = req_addr_i[k*ADDR_W +: ADDR_W];
            end
        end
    end

    // Grant is combinational in IDLE; gated by reset so nothing is offered while held in reset
    assign req_ready_o = (reset_n && state_q == IDLE && win_vld_c) ? (NUM_REQ'(1) << win_id_c) : '0;

`ifdef PIO_RDCHG_EN
    logic [DATA_W-1:0] shadow_q [2**ADDR_W];
    logic              chg_q, chg_d;
`endif

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        read_d      = read_q;
        busy_d      = busy_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
`ifdef PIO_RDCHG_EN
        chg_d       = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (win_vld_c) begin
                    state_d = WAIT;
                    id_d    = win_id_c;
                    addr_d  = win_addr_c;
                    read_d  = 1'b1;
                    busy_d  = 1'b1;
                    ptr_d   = wrap_add(win_id_c, 1);
                    cnt_d   = CNT_W'(RD_LATENCY);
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d     = RESP;
                    rsp_data_d  = slv_readdata_i;
                    rsp_valid_d = NUM_REQ'(1) << id_q;
                    read_d      = 1'b0;
                    busy_d      = 1'b0;
`ifdef PIO_RDCHG_EN
                    chg_d       = (slv_readdata_i != shadow_q[addr_q]);
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
            read_q      <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            read_q      <= read_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

`ifdef PIO_RDCHG_EN
    // Shadow remembers the last word returned per address; updated as the response leaves
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chg_q <= 1'b0;
            for (int i = 0; i < 2**ADDR_W; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            chg_q <= chg_d;
            if (state_q == RESP) begin
                shadow_q[addr_q] <= rsp_data_q;
            end
        end
    end

    assign rsp_changed_o = chg_q;
`endif

    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_data_o    = rsp_data_q;
    assign busy_o        = busy_q;
    assign slv_address_o = addr_q;
    assign slv_read_o    = read_q;

endmodule

// File: tb/tb_pio_read_arbiter.sv
// Directed bench for pio_read_arbiter: one instance at RD_LATENCY=1 and one at RD_LATENCY=3, each with a latency-accurate slave model.
module tb_pio_read_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned AW = 2;
    localparam int unsigned DW = 32;
    localparam logic [DW-1:0] JUNK = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mem [4];

    // Instance with RD_LATENCY=1
    logic              rst1_n = 1'b0;
    logic [NR-1:0]     v1 = '0;
    logic [NR*AW-1:0]  a1 = '0;
    logic [NR-1:0]     rdy1, rv1;
    logic [DW-1:0]     rd1, srd1;
    logic              busy1, sr1;
    logic [AW-1:0]     sa1;
`ifdef PIO_RDCHG_EN
    logic              chg1, chg3;
`endif

    // Instance with RD_LATENCY=3
    logic              rst3_n = 1'b0;
    logic [NR-1:0]     v3 = '0;
    logic [NR*AW-1:0]  a3 = '0;
    logic [NR-1:0]     rdy3, rv3;
    logic [DW-1:0]     rd3, srd3;
    logic              busy3, sr3;
    logic [AW-1:0]     sa3;

    pio_read_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1)) dut1 (
        .clk            (clk),
        .reset_n        (rst1_n),
        .req_valid_i    (v1),
        .req_addr_i     (a1),
        .req_ready_o    (rdy1),
        .rsp_valid_o    (rv1),
        .rsp_data_o     (rd1),
`ifdef PIO_RDCHG_EN
        .rsp_changed_o  (chg1),
`endif
        .busy_o         (busy1),
        .slv_address_o  (sa1),
        .slv_read_o     (sr1),
        .slv_readdata_i (srd1)
    );

    pio_read_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(3)) dut3 (
        .clk            (clk),
        .reset_n        (rst3_n),
        .req_valid_i    (v3),
        .req_addr_i     (a3),
        .req_ready_o    (rdy3),
        .rsp_valid_o    (rv3),
        .rsp_data_o     (rd3),
`ifdef PIO_RDCHG_EN
        .rsp_changed_o  (chg3),
`endif
        .busy_o         (busy3),
        .slv_address_o  (sa3),
        .slv_read_o     (sr3),
        .slv_readdata_i (srd3)
    );

    // Slave models: word is valid exactly RD_LATENCY cycles after the address, junk otherwise
    logic [DW-1:0] pipe1 = '0;
    logic [DW-1:0] pipe3 [3] = '{default: '0};
    always @(posedge clk) begin
        pipe1    <= sr1 ? mem[sa1] : JUNK;
        pipe3[0] <= sr3 ? mem[sa3] : JUNK;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign srd1 = pipe1;
    assign srd3 = pipe3[2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic wait_grant1(output logic [NR-1:0] g);
        g = '0;
        for (int i = 0; i < 20 && g == '0; i++) begin
            @(negedge clk);
            g = rdy1;
        end
    endtask

`ifdef PIO_RDCHG_EN
    task automatic read_chg(input int id, input logic [DW-1:0] word, input logic exp_chg);
        logic [NR-1:0] g;
        logic [NR-1:0] r;
        logic          c;
        logic [DW-1:0] d;
        step();
        mem[1]          = word;
        v1[id]          = 1'b1;
        a1[id*AW +: AW] = 2'd1;
        wait_grant1(g);
        check("t6_grant", 64'(g), 64'(NR'(1) << id));
        step();
        v1[id] = 1'b0;
        r = '0;
        c = 1'b0;
        d = '0;
        for (int i = 0; i < 10 && r == '0; i++) begin
            @(negedge clk);
            r = rv1;
            c = chg1;
            d = rd1;
        end
        check("t6_rsp", 64'(r), 64'(NR'(1) << id));
        check("t6_data", 64'(d), 64'(word));
        check("t6_changed", 64'(c), 64'(exp_chg));
        smp();
        check("t6_changed_idle", 64'(chg1), 64'd0);
    endtask
`endif

    int            gcy [5];
    logic [NR-1:0] gvec [5];
    int            rcy [5];
    logic [NR-1:0] rvec [5];
    logic [DW-1:0] rdat [5];
    int            ng, nr, a_cyc;
    logic [NR-1:0] g, acc;
    logic [DW-1:0] exp_word [4];

    initial begin
        exp_word[0] = 32'h0000_00A0;
        exp_word[1] = 32'h0000_00B1;
        exp_word[2] = 32'h0000_00C2;
        exp_word[3] = 32'h0000_00D3;
        for (int i = 0; i < 4; i++) mem[i] = 32'h0;

        // Reset with random request traffic: every output must sit at 0
        for (int i = 0; i < 3; i++) begin
            step();
            v1 = NR'($urandom);
            a1 = (NR*AW)'($urandom);
            v3 = NR'($urandom);
            smp();
            check("rst_outs1", 64'({rdy1, rv1, rd1, busy1, sa1, sr1}), 64'd0);
            check("rst_outs3", 64'({rdy3, rv3, rd3, busy3, sa3, sr3}), 64'd0);
`ifdef PIO_RDCHG_EN
            check("rst_chg", 64'({chg1, chg3}), 64'd0);
`endif
        end
        step();
        v1 = '0;
        v3 = '0;
        rst1_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            smp();
            check("idle_quiet", 64'({rdy1, rv1, busy1, sr1}), 64'd0);
        end

        // Single read, latency 1: A, slave access A+1..A+2, response A+3
        mem[0] = 32'h0000_00A5;
        step();
        v1 = 4'b0001;
        a1 = '0;
        smp();
        check("t2_ready", 64'(rdy1), 64'h1);
        for (int i = 1; i <= 2; i++) begin
            step();
            v1 = '0;
            smp();
            check("t2_access", 64'({sr1, sa1, busy1, rv1, rdy1}), 64'({1'b1, 2'd0, 1'b1, 4'b0000, 4'b0000}));
        end
        step();
        smp();
        check("t2_rsp_valid", 64'(rv1), 64'h1);
        check("t2_rsp_data", 64'(rd1), 64'hA5);
        check("t2_rsp_idle", 64'({busy1, sr1}), 64'd0);
        step();
        smp();
        check("t2_rsp_drop", 64'(rv1), 64'd0);
        check("t2_data_hold", 64'(rd1), 64'hA5);

        // All four requesters valid from reset: rotation 0,1,2,3,0 every 4 cycles
        for (int i = 0; i < 4; i++) mem[i] = exp_word[i];
        step();
        rst1_n = 1'b0;
        v1 = 4'hF;
        a1 = {2'd3, 2'd2, 2'd1, 2'd0};
        step();
        rst1_n = 1'b1;
        ng = 0;
        nr = 0;
        for (int i = 0; i < 26; i++) begin
            smp();
            if (rdy1 != '0 && ng < 5) begin
                gcy[ng]  = cyc;
                gvec[ng] = rdy1;
                ng++;
            end
            if (rv1 != '0 && nr < 5) begin
                rcy[nr]  = cyc;
                rvec[nr] = rv1;
                rdat[nr] = rd1;
                nr++;
            end
        end
        check("t3_ngrant", 64'(ng), 64'd5);
        check("t3_nrsp", 64'(nr), 64'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < ng) begin
                check("t3_grant", 64'(gvec[k]), 64'(NR'(1) << (k % 4)));
                check("t3_spacing", 64'(gcy[k] - gcy[0]), 64'(4 * k));
            end
            if (k < ng && k < nr) begin
                check("t3_rsp_id", 64'(rvec[k]), 64'(gvec[k]));
                check("t3_rsp_lat", 64'(rcy[k] - gcy[k]), 64'd3);
                check("t3_rsp_data", 64'(rdat[k]), 64'(exp_word[k % 4]));
            end
        end
        step();
        v1 = '0;
        repeat (6) step();

        // Grant 2, then 1 and 3 together: 3 wins, then 1
        rst1_n = 1'b0;
        step();
        rst1_n = 1'b1;
        v1 = 4'b0100;
        smp();
        check("t4_grant2", 64'(rdy1), 64'h4);
        step();
        v1 = 4'b1010;
        smp();
        check("t4_busy_noready", 64'(rdy1), 64'd0);
        wait_grant1(g);
        check("t4_first", 64'(g), 64'h8);
        step();
        v1 = v1 & ~g;
        wait_grant1(g);
        check("t4_second", 64'(g), 64'h2);
        step();
        v1 = '0;
        repeat (6) step();

        // Latency 3: reset mid-access aborts it and returns the pointer to 0
        rst3_n = 1'b1;
        mem[2] = 32'h1234_5678;
        mem[1] = 32'h0000_0055;
        v3 = 4'b0001;
        a3 = {2'd3, 2'd2, 2'd1, 2'd2};
        smp();
        check("t5_grant0", 64'(rdy3), 64'h1);
        step();
        v3 = '0;
        smp();
        check("t5_wait", 64'({sr3, busy3}), 64'b11);
        step();
        rst3_n = 1'b0;
        smp();
        check("t5_abort_outs", 64'({rdy3, rv3, rd3, busy3, sa3, sr3}), 64'd0);
        step();
        rst3_n = 1'b1;
        acc = '0;
        for (int i = 0; i < 10; i++) begin
            smp();
            acc = acc | rv3;
        end
        check("t5_no_rsp", 64'(acc), 64'd0);
        step();
        v3 = 4'b0011;
        smp();
        a_cyc = cyc;
        check("t5_ptr_reset", 64'(rdy3), 64'h1);
        for (int i = 1; i <= 4; i++) begin
            step();
            v3 = 4'b0010;
            smp();
            check("t5_access", 64'({sr3, sa3, rv3, rdy3}), 64'({1'b1, 2'd2, 4'b0000, 4'b0000}));
        end
        step();
        smp();
        check("t5_rsp_cycle", 64'(cyc - a_cyc), 64'd5);
        check("t5_rsp_valid", 64'(rv3), 64'h1);
        check("t5_rsp_data", 64'(rd3), 64'h1234_5678);
        step();
        v3 = '0;
        repeat (8) step();

`ifdef PIO_RDCHG_EN
        // Change detect: 5, 5, 7 from address 1
        rst1_n = 1'b0;
        step();
        rst1_n = 1'b1;
        read_chg(1, 32'h5, 1'b1);
        read_chg(1, 32'h5, 1'b0);
        read_chg(1, 32'h7, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
